// File: rtl/anthill_uart_pkg.sv
// Shared UART definitions for the anthill SoC, used by both the RX and TX blocks.
// Holds the receiver state encoding, frame width and the bit-period helper.
package anthill_uart_pkg;

   localparam int c_uart_data_bits = 8;
   localparam int c_sim_clks_per_bit = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } t_rx_state;

   // Simulation builds shrink the bit period so full frames stay short.
   function automatic int f_effective_cpb(input int sim, input int cpb);
      return (sim != 0) ? c_sim_clks_per_bit : cpb;
   endfunction

endpackage

// File: rtl/anthill_uart_rx_if.sv
// Byte hand-off between the UART receiver and the bus-side register file.
// The receiver drives the master modport and the consumer drives the slave modport.
interface anthill_uart_rx_if;
   import anthill_uart_pkg::*;

   logic [c_uart_data_bits-1:0] rx_data_o;
   logic                        rx_valid_o;
   logic                        rx_ready_i;

   modport master (
      output rx_data_o,
      output rx_valid_o,
      input  rx_ready_i
   );

   modport slave (
      input  rx_data_o,
      input  rx_valid_o,
      output rx_ready_i
   );

endinterface

// File: rtl/anthill_sync2.sv
// Two-flop synchroniser for a single asynchronous input.
// The reset value is chosen per use so an idle line reads as idle straight out of reset.
module anthill_sync2 #(
   parameter logic g_reset_val = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_sync
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= g_reset_val;
         r_sync <= g_reset_val;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

// File: rtl/anthill_uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM feeding a one-entry valid/ready buffer.
// Framing errors and overruns are reported as single-cycle pulses.
module anthill_uart_rx
   import anthill_uart_pkg::*;
#(
   parameter int g_clks_per_bit = 868,
   parameter int g_simulation   = 0
) (
   input  logic                    CLK100MHZ,
   input  logic                    resetn,
   input  logic                    uart_rxd_i,
   anthill_uart_rx_if.master       rx_bus,
   output logic                    frame_err_o,
   output logic                    overrun_o,
   output logic                    busy_o
);

   localparam int c_cpb   = f_effective_cpb(g_simulation, g_clks_per_bit);
   localparam int c_cnt_w = $clog2(c_cpb);
   localparam int c_idx_w = $clog2(c_uart_data_bits);

   localparam logic [c_cnt_w-1:0] c_cnt_half = c_cnt_w'(c_cpb / 2 - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(c_cpb - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
   localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(c_uart_data_bits - 1);
   localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);

   logic w_rxs;

   t_rx_state r_state;
   t_rx_state w_state_nxt;

   logic [c_cnt_w-1:0]          r_cnt;
   logic [c_cnt_w-1:0]          w_cnt_nxt;
   logic [c_idx_w-1:0]          r_idx;
   logic [c_idx_w-1:0]          w_idx_nxt;
   logic [c_uart_data_bits-1:0] r_shift;
   logic [c_uart_data_bits-1:0] w_shift_nxt;

   logic w_tick;
   logic w_good;
   logic w_ferr;
   logic w_take;
   logic w_load;
   logic w_ovr;

   logic [c_uart_data_bits-1:0] r_data;
   logic                        r_valid;
   logic                        r_ferr;
   logic                        r_ovr;
   logic                        r_busy;

   anthill_sync2 #(
      .g_reset_val (1'b1)
   ) u_sync (
      .i_clk   (CLK100MHZ),
      .i_rst_n (resetn),
      .i_async (uart_rxd_i),
      .o_sync  (w_rxs)
   );

   assign w_tick = (r_cnt == '0);

   always_ff @(posedge CLK100MHZ or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_shift <= w_shift_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = w_tick ? r_cnt : (r_cnt - c_cnt_one);
      w_idx_nxt   = r_idx;
      w_shift_nxt = r_shift;
      w_good      = 1'b0;
      w_ferr      = 1'b0;

      case (r_state)
         IDLE: begin
            if (!w_rxs) begin
               w_state_nxt = START;
               w_cnt_nxt   = c_cnt_half;
            end
         end
         START: begin
            // A start bit that is high again at mid-bit was only a glitch.
            if (w_tick) begin
               if (!w_rxs) begin
                  w_state_nxt = DATA;
                  w_cnt_nxt   = c_cnt_full;
                  w_idx_nxt   = '0;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         DATA: begin
            if (w_tick) begin
               w_shift_nxt = {w_rxs, r_shift[c_uart_data_bits-1:1]};
               w_cnt_nxt   = c_cnt_full;
               if (r_idx == c_idx_last) begin
                  w_state_nxt = STOP;
               end else begin
                  w_idx_nxt = r_idx + c_idx_one;
               end
            end
         end
         STOP: begin
            if (w_tick) begin
               if (w_rxs) begin
                  w_good      = 1'b1;
                  w_state_nxt = IDLE;
               end else begin
                  w_ferr      = 1'b1;
                  w_state_nxt = BREAK;
               end
            end
         end
         BREAK: begin
            if (w_rxs) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // A byte may load into a full buffer only when the old byte leaves in the same cycle.
   assign w_take = r_valid & rx_bus.rx_ready_i;
   assign w_load = w_good & (~r_valid | w_take);
   assign w_ovr  = w_good & r_valid & ~w_take;

   always_ff @(posedge CLK100MHZ or negedge resetn) begin
      if (!resetn) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
         r_ovr   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         if (w_load) begin
            r_data  <= r_shift;
            r_valid <= 1'b1;
         end else if (w_take) begin
            r_valid <= 1'b0;
         end
         r_ferr <= w_ferr;
         r_ovr  <= w_ovr;
         r_busy <= (w_state_nxt != IDLE);
      end
   end

   assign rx_bus.rx_data_o  = r_data;
   assign rx_bus.rx_valid_o = r_valid;
   assign frame_err_o       = r_ferr;
   assign overrun_o         = r_ovr;
   assign busy_o            = r_busy;

endmodule

// File: tb/tb_anthill_uart_rx.sv
// Scoreboard bench for anthill_uart_rx: a serial line model queues expected bytes,
// and a negedge monitor pops and compares every accepted byte.
module tb_anthill_uart_rx;

   localparam int cpb = 16;

   logic clk;
   logic resetn;
   logic rxd;
   logic frameErr;
   logic overrun;
   logic busy;

   anthill_uart_rx_if rxIf ();

   anthill_uart_rx #(
      .g_clks_per_bit (868),
      .g_simulation   (1)
   ) dut (
      .CLK100MHZ   (clk),
      .resetn      (resetn),
      .uart_rxd_i  (rxd),
      .rx_bus      (rxIf),
      .frame_err_o (frameErr),
      .overrun_o   (overrun),
      .busy_o      (busy)
   );

   // Free-running clock and a cycle counter used for latency measurement.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cycleCnt = 0;
   always @(posedge clk) cycleCnt++;

   int total = 0;
   int bad = 0;
   int ferrCnt = 0;
   int ovrCnt = 0;
   int startCycle = 0;
   int lastXferCycle = 0;
   logic [7:0] expQ[$];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Drives one 8N1 frame; must be called at a negedge and returns at the negedge
   // where the next frame may start, so consecutive calls have zero idle gap.
   task automatic applyStimulus(input logic [7:0] data, input logic stopHigh);
      startCycle = cycleCnt;
      rxd = 1'b0;
      repeat (cpb) @(negedge clk);
      for (int b = 0; b < 8; b++) begin
         rxd = data[b];
         repeat (cpb) @(negedge clk);
      end
      rxd = stopHigh;
      repeat (cpb) @(negedge clk);
      rxd = 1'b1;
   endtask

   // Monitor: counts error pulses and checks every accepted byte against the queue.
   always @(negedge clk) begin
      if (resetn) begin
         if (frameErr) ferrCnt++;
         if (overrun) ovrCnt++;
         if (rxIf.rx_valid_o && rxIf.rx_ready_i) begin
            lastXferCycle = cycleCnt;
            if (expQ.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpectedByte: got=%0h expected=none", rxIf.rx_data_o);
            end else begin
               checkOutput("rxData", {24'h0, rxIf.rx_data_o}, {24'h0, expQ.pop_front()});
            end
         end
      end
   end

   initial begin
      repeat (30000) @(posedge clk);
      $display("[TB] FAIL watchdog: got=timeout expected=finish");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_data"},  {24'h0, rxIf.rx_data_o}, 32'h0);
      checkOutput({tag, "_valid"}, {31'h0, rxIf.rx_valid_o}, 32'h0);
      checkOutput({tag, "_ferr"},  {31'h0, frameErr}, 32'h0);
      checkOutput({tag, "_ovr"},   {31'h0, overrun}, 32'h0);
      checkOutput({tag, "_busy"},  {31'h0, busy}, 32'h0);
   endtask

   initial begin
      resetn = 1'b0;
      rxd = 1'b1;
      rxIf.rx_ready_i = 1'b1;
      repeat (3) @(negedge clk);
      checkResetOutputs("reset");
      @(posedge clk);
      #1 resetn = 1'b1;
      repeat (5) @(negedge clk);

      $display("[TB] single frame 0xA5");
      expQ.push_back(8'hA5);
      applyStimulus(8'hA5, 1'b1);
      repeat (4) @(negedge clk);
      checkOutput("latencyA5", lastXferCycle - startCycle, 155);
      checkOutput("ferrAfterA5", ferrCnt, 0);
      checkOutput("ovrAfterA5", ovrCnt, 0);

      $display("[TB] 5-cycle glitch");
      rxd = 1'b0;
      repeat (5) @(negedge clk);
      rxd = 1'b1;
      repeat (40) @(negedge clk);
      checkOutput("busyAfterGlitch", {31'h0, busy}, 0);
      checkOutput("ferrAfterGlitch", ferrCnt, 0);
      checkOutput("validAfterGlitch", {31'h0, rxIf.rx_valid_o}, 0);

      $display("[TB] framing error and break");
      applyStimulus(8'h3C, 1'b0);
      rxd = 1'b0;
      repeat (40 * cpb) @(negedge clk);
      checkOutput("busyInBreak", {31'h0, busy}, 1);
      checkOutput("ferrInBreak", ferrCnt, 1);
      rxd = 1'b1;
      repeat (2 * cpb) @(negedge clk);
      checkOutput("ferrAfterBreak", ferrCnt, 1);
      checkOutput("busyAfterBreak", {31'h0, busy}, 0);
      expQ.push_back(8'h11);
      applyStimulus(8'h11, 1'b1);
      repeat (4) @(negedge clk);
      checkOutput("ferrAfter11", ferrCnt, 1);

      $display("[TB] overrun with consumer stalled");
      @(posedge clk);
      #1 rxIf.rx_ready_i = 1'b0;
      @(negedge clk);
      expQ.push_back(8'h01);
      applyStimulus(8'h01, 1'b1);
      applyStimulus(8'h02, 1'b1);
      repeat (4) @(negedge clk);
      checkOutput("ovrValid", {31'h0, rxIf.rx_valid_o}, 1);
      checkOutput("ovrHeldData", {24'h0, rxIf.rx_data_o}, 32'h01);
      checkOutput("ovrCount", ovrCnt, 1);
      @(posedge clk);
      #1 rxIf.rx_ready_i = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("validAfterDrain", {31'h0, rxIf.rx_valid_o}, 0);

      $display("[TB] ten back-to-back frames");
      for (int i = 0; i < 10; i++) begin
         expQ.push_back(8'(i));
         applyStimulus(8'(i), 1'b1);
      end
      repeat (4) @(negedge clk);
      checkOutput("b2bQueueEmpty", expQ.size(), 0);
      checkOutput("b2bFerr", ferrCnt, 1);
      checkOutput("b2bOvr", ovrCnt, 1);

      $display("[TB] reset during bit 4");
      fork
         applyStimulus(8'hF0, 1'b1);
         begin
            repeat (84) @(negedge clk);
            resetn = 1'b0;
            repeat (2) @(negedge clk);
            checkResetOutputs("midReset");
            resetn = 1'b1;
         end
      join
      repeat (20) @(negedge clk);
      checkOutput("validAfterAbort", {31'h0, rxIf.rx_valid_o}, 0);
      expQ.push_back(8'hC3);
      applyStimulus(8'hC3, 1'b1);
      repeat (4) @(negedge clk);
      checkOutput("finalQueueEmpty", expQ.size(), 0);
      checkOutput("finalFerr", ferrCnt, 1);
      checkOutput("finalOvr", ovrCnt, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
